// File: rtl/lab8_soc_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory with
// one-cycle read latency; read data is steered back to the master that issued it.
module lab8_soc_onchip_mem_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    output logic                mem_reset_req,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                proto_err
);

    logic req0, req1;
    logic gnt0, gnt1;
    logic last_grant;
    logic rd_vld_p1;
    logic rd_owner_p1;
    logic proto_err_q;

    // Grant stage: combinational, one requester per cycle, nothing during reset
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    assign mem_chipselect = gnt0 | gnt1;
    // Read+write together is a write; the error flag records the violation
    assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
    assign mem_address    = gnt1 ? m1_address    : m0_address;
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;

    assign mem_clken     = ~reset;
    assign mem_reset_req = reset;

    // Return stage: memory data fans out, valid only to the owner of the read
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_vld_p1 & ~rd_owner_p1 & ~reset;
    assign m1_readdatavalid = rd_vld_p1 &  rd_owner_p1 & ~reset;

    assign proto_err = proto_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 1'b1;
            rd_vld_p1   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (gnt0 | gnt1) begin
                last_grant  <= gnt1;
                rd_owner_p1 <= gnt1;
            end
            rd_vld_p1 <= (gnt0 | gnt1) & ~mem_write;
            if ((m0_read && m0_write) || (m1_read && m1_write))
                proto_err_q <= 1'b1;
        end
    end

endmodule

// File: doc/lab8_soc_onchip_mem_arbiter.md
LAB8_SOC_ONCHIP_MEM_ARBITER -- requirements
Module: lab8_soc_onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, word-address width of the shared on-chip memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports m0_address/m1_address  input  ADDR_W  requester word address.
REQ-006 SHALL have ports m0_read/m1_read, m0_write/m1_write  input  1 each  transfer request.
REQ-007 SHALL have ports m0_byteenable/m1_byteenable  input  DATA_W/8, and m0_writedata/m1_writedata  input  DATA_W.
REQ-008 SHALL have ports m0_waitrequest/m1_waitrequest  output  1  request not accepted this cycle.
REQ-009 SHALL have ports m0_readdata/m1_readdata  output  DATA_W, and m0_readdatavalid/m1_readdatavalid  output  1.
REQ-010 SHALL have memory-side ports mem_address  output  ADDR_W, mem_byteenable  output  DATA_W/8, mem_chipselect  output  1, mem_write  output  1, mem_writedata  output  DATA_W, mem_clken  output  1, mem_reset_req  output  1, mem_readdata  input  DATA_W.
REQ-011 SHALL have port proto_err  output  1  sticky flag for requester protocol violation.

Function
REQ-012 Requester m is requesting in a cycle iff mN_read|mN_write is high.
REQ-013 Arbitration SHALL be combinational within the cycle: exactly one requesting master is granted per cycle; the granted master's waitrequest is low and the transfer is accepted at the rising edge ending that cycle.
REQ-014 Non-granted requesting masters SHALL see waitrequest high and SHALL hold their request until granted; idle masters SHALL see waitrequest high.
REQ-015 Round-robin: register last_grant (0/1); when both request, grant goes to the master not equal to last_grant; when one requests, it is granted regardless of last_grant.
REQ-016 last_grant SHALL update to the granted master at every accepted transfer and hold otherwise.
REQ-017 In a grant cycle mem_chipselect=1, mem_address/byteenable/writedata come from the granted master, mem_write = granted master's write; with no grant mem_chipselect=0, mem_write=0, others don't-care.
REQ-018 Reads: memory latency is one cycle; a read accepted at edge N SHALL produce mN_readdatavalid=1 with mN_readdata=mem_readdata during cycle N+1, exactly one cycle, only to the owning master.
REQ-019 A pending-read register (valid + owner) SHALL track the in-flight read; back-to-back reads from either master SHALL be accepted every cycle (full throughput, no bubbles).
REQ-020 Non-owner readdatavalid SHALL be 0; readdata outputs MAY be driven with mem_readdata to both masters.
REQ-021 Writes complete at acceptance; no readdatavalid for writes.
REQ-022 Read then write to the same address in consecutive cycles SHALL return the pre-write data for the read.
REQ-023 If a master asserts read and write together, it SHALL be treated as a write, and proto_err SHALL be set and held until reset.
REQ-024 mem_clken SHALL be 1 whenever reset is low; mem_reset_req SHALL equal reset.

Reset
REQ-025 While reset is high at a clock edge: last_grant<=1 (so m0 wins the first contention), pending-read valid<=0, proto_err<=0.
REQ-026 During reset cycles both waitrequest outputs SHALL be 1, mem_chipselect=0, mem_write=0, both readdatavalid=0.
REQ-027 A read accepted in the cycle before reset asserts SHALL NOT produce readdatavalid after reset.

Verification
REQ-028 Single write then read: m0 writes addr 2 data 0xDEADBEEF be=0xF; m0 reads addr 2 -> m0_readdatavalid one cycle after accept, m0_readdata=0xDEADBEEF.
REQ-029 Byte enables: word 1 = 0x11223344; m1 writes 0xAABBCCDD be=0x5 -> read addr 1 returns 0x11BB3344... corrected: returns 0x11BB33DD.
REQ-030 Contention: m0 and m1 both read continuously for 6 cycles after reset -> grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid only to owner, one cycle after its grant.
REQ-031 Read-before-write: word 3=0x1; m0 reads 3, m1 writes 3=0x2 next cycle -> m0 gets 0x1; a later read returns 0x2.
REQ-032 Protocol error: m1 asserts read and write at addr 0 data 0x5 -> memory written 0x5, no m1_readdatavalid, proto_err=1 until reset.
REQ-033 Reset mid-read: m0 read accepted, reset asserted next cycle -> m0_readdatavalid stays 0, waitrequests 1, proto_err 0.
